// File: rtl/rv_pkg.sv
// Shared definitions for the register-file writeback path: widths, requester
// indices and the writeback request record.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int REG_W = 5;
  localparam int NREQ  = 3;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_LSU = 2'd1;
  localparam logic [1:0] REQ_CSR = 2'd2;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  // Reduce a value in 0..5 to a requester index in 0..2.
  function automatic logic [1:0] rr_wrap(input logic [2:0] v);
    rr_wrap = (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter. The pointer names the highest-priority
// requester and moves just past the winner whenever a grant is taken.
module rr_arbiter3
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] valid,
  input  logic       advance,
  output logic [2:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] ptr;

  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant     = 3'b000;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = rr_wrap(3'({1'b0, ptr}) + 3'(k));
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= REQ_ALU;
    end else if (advance) begin
      ptr <= rr_wrap(3'({1'b0, grant_idx}) + 3'd1);
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single regfile write port among ALU, LSU and CSR writeback
// and tracks outstanding destinations for RAW hazard detection.
module rf_wb_scheduler
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*REG_W-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]  req_data,
  input  logic                  iss_valid,
  input  logic [REG_W-1:0]      iss_rd,
  input  logic [REG_W-1:0]      chk_rs1,
  input  logic [REG_W-1:0]      chk_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  rf_ld,
  output logic [REG_W-1:0]      rf_dest,
  output logic [XLEN-1:0]       rf_data,
  output logic                  idle
);

  logic [2:0]       grant;
  logic [1:0]       grant_idx;
  logic             transfer;
  wb_req_t          sel;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  rr_arbiter3 u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid     (req_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(req_valid & grant);

  always_comb begin
    sel = '0;
    case (grant_idx)
      REQ_ALU: sel = '{rd: req_rd[0*REG_W +: REG_W], data: req_data[0*XLEN +: XLEN]};
      REQ_LSU: sel = '{rd: req_rd[1*REG_W +: REG_W], data: req_data[1*XLEN +: XLEN]};
      REQ_CSR: sel = '{rd: req_rd[2*REG_W +: REG_W], data: req_data[2*XLEN +: XLEN]};
      default: sel = '0;
    endcase
  end

  // x0 writes are consumed so the requester is not stalled, but never reach the regfile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_ld   <= 1'b0;
      rf_dest <= '0;
      rf_data <= '0;
    end else if (transfer && sel.rd != '0) begin
      rf_ld   <= 1'b1;
      rf_dest <= sel.rd;
      rf_data <= sel.data;
    end else begin
      rf_ld   <= 1'b0;
    end
  end

  // Set is applied after clear so a newly issued producer keeps its register busy.
  always_comb begin
    busy_next = busy;
    if (transfer && sel.rd != '0) busy_next[sel.rd] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // The rf_ld term covers the cycle before the regfile actually holds the value.
  assign busy_rs1 = busy[chk_rs1] | (rf_ld && rf_dest == chk_rs1 && chk_rs1 != '0);
  assign busy_rs2 = busy[chk_rs2] | (rf_ld && rf_dest == chk_rs2 && chk_rs2 != '0);
  assign idle     = ~(|busy) & ~rf_ld;

endmodule
